vga_scan_timing: RTL

Pixel-clock scan generator for the 640x480 @ 60 Hz display. It owns the horizontal and vertical counters and drives the `on`, `colPos` and `rowPos` scan coordinates that the background and sprite renderers consume. It takes the renderer's returned 6-bit `color` and registers it to the DAC pins with `hsync`/`vsync` delayed to match. It also provides frame-rate strobes (vblank pulse, frame counter) for game-logic pacing.

---
 rtl/vga_scan_timing.sv | 95 +++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// Pixel-clock scan generator: horizontal/vertical counters, visible-area flag,
// registered DAC output stage with matching sync delay, and frame-rate strobes.
module vga_scan_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] color,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic       on,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       vblank_pulse,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] frame_q, frame_d;
  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic       h_wrap, v_wrap, on_now;

  // Next-state for counters and the one-clk-delayed output stage.
  always_comb begin
    h_wrap  = (h_q == HLast);
    v_wrap  = (v_q == VLast);
    on_now  = (h_q < HActive) && (v_q < VActive);
    h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d     = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    frame_d = (h_wrap && v_wrap) ? frame_q + 8'd1 : frame_q;
    // Blanking is forced black regardless of what the renderer returns.
    rgb_d    = on_now ? color : 6'd0;
    hsync_d  = !((h_q >= HsStart) && (h_q <= HsEnd));
    vsync_d  = !((v_q >= VsStart) && (v_q <= VsEnd));
    vblank_d = (h_q == 10'd0) && (v_q == VActive);
  end

  // State registers; reset clears everything at once, no line completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      frame_q  <= 8'd0;
      rgb_q    <= 6'd0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
    end
  end

  assign colPos       = h_q;
  assign rowPos       = v_q;
  assign on           = on_now;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign rgb          = rgb_q;
  assign vblank_pulse = vblank_q;
  assign frame_cnt    = frame_q;

endmodule
